// File: rtl/bl_mask_burst.sv
// Burst bitline-mask generator: accepts a (column, word-width, length) request and
// streams one registered bitline mask per beat, stepping and wrapping within the row.
module bl_mask_burst #(
    parameter int ROW_BITS = 32,
    parameter int ADDR_W   = 5,
    parameter int CONF_W   = 3,
    parameter int LEN_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [CONF_W-1:0]   req_conf,
    input  logic [LEN_W-1:0]    req_len,
    output logic                mask_valid,
    input  logic                mask_ready,
    output logic [ROW_BITS-1:0] mask,
    output logic [ADDR_W-1:0]   mask_addr,
    output logic                mask_last,
    output logic                mask_wrap,
    output logic                mask_clamped
);

    // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
    // a valid source holds its payload stable until that edge.

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CONF_W-1:0]   conf_q, conf_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [ROW_BITS-1:0] mask_q, mask_d;
    logic                wrap_q, wrap_d;
    logic                clamped_q, clamped_d;

    logic                req_clamp;
    logic [CONF_W-1:0]   eff_conf;
    logic [ADDR_W-1:0]   base_addr;
    logic                accept;
    logic                beat_fire;
    logic                last_fire;
    logic [ADDR_W:0]     step;
    logic [ADDR_W:0]     sum;

    // Bits [a, a + 2^c) set; the caller guarantees a is aligned so the group fits the row.
    function automatic logic [ROW_BITS-1:0] build_mask(input logic [ADDR_W-1:0] a,
                                                       input logic [CONF_W-1:0] c);
        logic [ROW_BITS-1:0] m;
        int lo;
        int hi;
        lo = int'(a);
        hi = lo + (1 << int'(c));
        for (int i = 0; i < ROW_BITS; i++) begin
            m[i] = (i >= lo) && (i < hi);
        end
        return m;
    endfunction

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a,
                                                input logic [CONF_W-1:0] c);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = (i >= int'(c)) ? a[i] : 1'b0;
        end
        return r;
    endfunction

    assign req_clamp = int'(req_conf) > ADDR_W;
    assign eff_conf  = req_clamp ? CONF_W'(ADDR_W) : req_conf;
    assign base_addr = align(req_addr, eff_conf);

    assign mask_valid   = (state_q == BURST);
    assign mask_last    = (state_q == BURST) && (cnt_q == '0);
    assign mask         = mask_q;
    assign mask_addr    = addr_q;
    assign mask_wrap    = wrap_q;
    assign mask_clamped = clamped_q;

    assign beat_fire = mask_valid && mask_ready;
    assign last_fire = beat_fire && mask_last;

    // Opening the request port on the final handshake gives back-to-back bursts no bubble.
    assign req_ready = !rst && ((state_q == IDLE) || last_fire);
    assign accept    = req_valid && req_ready;

    // The carry out of the address add is exactly the wrap indication.
    assign step = (ADDR_W+1)'(1) << conf_q;
    assign sum  = {1'b0, addr_q} + step;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        conf_d    = conf_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        wrap_d    = wrap_q;
        clamped_d = clamped_q;
        if (accept) begin
            state_d   = BURST;
            addr_d    = base_addr;
            conf_d    = eff_conf;
            cnt_d     = req_len;
            mask_d    = build_mask(base_addr, eff_conf);
            wrap_d    = 1'b0;
            clamped_d = req_clamp;
        end else if (last_fire) begin
            state_d   = IDLE;
            addr_d    = '0;
            conf_d    = '0;
            cnt_d     = '0;
            mask_d    = '0;
            wrap_d    = 1'b0;
            clamped_d = 1'b0;
        end else if (beat_fire) begin
            addr_d = sum[ADDR_W-1:0];
            cnt_d  = cnt_q - 1'b1;
            mask_d = build_mask(sum[ADDR_W-1:0], conf_q);
            wrap_d = sum[ADDR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            conf_q    <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            wrap_q    <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            conf_q    <= conf_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            wrap_q    <= wrap_d;
            clamped_q <= clamped_d;
        end
    end

endmodule

// File: tb/tb_bl_mask_burst.sv
// Directed bench for bl_mask_burst: a table of bursts with hand-computed beats,
// plus hand-written stall, back-to-back and mid-burst reset sequences.
module tb_bl_mask_burst;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr;
    logic [2:0]  req_conf;
    logic [3:0]  req_len;
    logic        mask_valid;
    logic        mask_ready;
    logic [31:0] mask;
    logic [4:0]  mask_addr;
    logic        mask_last;
    logic        mask_wrap;
    logic        mask_clamped;

    int n_checks = 0;
    int n_errors = 0;

    bl_mask_burst #(
        .ROW_BITS(32),
        .ADDR_W  (5),
        .CONF_W  (3),
        .LEN_W   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_conf    (req_conf),
        .req_len     (req_len),
        .mask_valid  (mask_valid),
        .mask_ready  (mask_ready),
        .mask        (mask),
        .mask_addr   (mask_addr),
        .mask_last   (mask_last),
        .mask_wrap   (mask_wrap),
        .mask_clamped(mask_clamped)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        first;
        logic [4:0]  addr;
        logic [2:0]  conf;
        logic [3:0]  len;
        logic [31:0] exp_mask;
        logic [4:0]  exp_addr;
        logic        exp_last;
        logic        exp_wrap;
        logic        exp_clamped;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic first, input logic [4:0] addr, input logic [2:0] conf,
                                input logic [3:0] len, input logic [31:0] m, input logic [4:0] ma,
                                input logic l, input logic w, input logic c);
        vec_t v;
        v.first = first; v.addr = addr; v.conf = conf; v.len = len;
        v.exp_mask = m; v.exp_addr = ma; v.exp_last = l; v.exp_wrap = w; v.exp_clamped = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] m, input logic [4:0] a,
                            input logic l, input logic w, input logic c);
        chk({tag, ".valid"},   32'(mask_valid),   32'd1);
        chk({tag, ".mask"},    mask,              m);
        chk({tag, ".addr"},    32'(mask_addr),    32'(a));
        chk({tag, ".last"},    32'(mask_last),    32'(l));
        chk({tag, ".wrap"},    32'(mask_wrap),    32'(w));
        chk({tag, ".clamped"}, 32'(mask_clamped), 32'(c));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".valid"},   32'(mask_valid),   32'd0);
        chk({tag, ".mask"},    mask,              32'd0);
        chk({tag, ".addr"},    32'(mask_addr),    32'd0);
        chk({tag, ".last"},    32'(mask_last),    32'd0);
        chk({tag, ".wrap"},    32'(mask_wrap),    32'd0);
        chk({tag, ".clamped"}, 32'(mask_clamped), 32'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Driver: present a request and hold it until accepted; returns with the first beat visible.
    task automatic issue(input logic [4:0] a, input logic [2:0] c, input logic [3:0] l);
        int n;
        req_addr  = a;
        req_conf  = c;
        req_len   = l;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            cyc();
            n++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_conf   = '0;
        req_len    = '0;
        mask_ready = 1'b0;

        vecs.push_back(mk(1, 21, 0, 0, 32'h0020_0000, 21, 1, 0, 0));
        vecs.push_back(mk(1, 21, 1, 2, 32'h0030_0000, 20, 0, 0, 0));
        vecs.push_back(mk(0, 21, 1, 2, 32'h00C0_0000, 22, 0, 0, 0));
        vecs.push_back(mk(0, 21, 1, 2, 32'h0300_0000, 24, 1, 0, 0));
        vecs.push_back(mk(1, 29, 3, 2, 32'hFF00_0000, 24, 0, 0, 0));
        vecs.push_back(mk(0, 29, 3, 2, 32'h0000_00FF,  0, 0, 1, 0));
        vecs.push_back(mk(0, 29, 3, 2, 32'h0000_FF00,  8, 1, 0, 0));
        vecs.push_back(mk(1, 13, 6, 0, 32'hFFFF_FFFF,  0, 1, 0, 1));
        vecs.push_back(mk(1,  7, 5, 1, 32'hFFFF_FFFF,  0, 0, 0, 0));
        vecs.push_back(mk(0,  7, 5, 1, 32'hFFFF_FFFF,  0, 1, 1, 0));
        vecs.push_back(mk(1, 30, 2, 3, 32'hF000_0000, 28, 0, 0, 0));
        vecs.push_back(mk(0, 30, 2, 3, 32'h0000_000F,  0, 0, 1, 0));
        vecs.push_back(mk(0, 30, 2, 3, 32'h0000_00F0,  4, 0, 0, 0));
        vecs.push_back(mk(0, 30, 2, 3, 32'h0000_0F00,  8, 1, 0, 0));
        vecs.push_back(mk(1,  5, 7, 1, 32'hFFFF_FFFF,  0, 0, 0, 1));
        vecs.push_back(mk(0,  5, 7, 1, 32'hFFFF_FFFF,  0, 1, 1, 1));
        vecs.push_back(mk(1, 17, 4, 0, 32'hFFFF_0000, 16, 1, 0, 0));

        // Reset state
        repeat (3) cyc();
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk_idle_outputs("rst");
        rst = 1'b0;
        cyc();
        chk("idle.req_ready", 32'(req_ready), 32'd1);
        chk("idle.valid", 32'(mask_valid), 32'd0);

        // Table-driven bursts with the consumer always ready
        mask_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].first) issue(vecs[i].addr, vecs[i].conf, vecs[i].len);
            chk_beat($sformatf("vec%0d", i), vecs[i].exp_mask, vecs[i].exp_addr,
                     vecs[i].exp_last, vecs[i].exp_wrap, vecs[i].exp_clamped);
            cyc();
            if (vecs[i].exp_last) chk($sformatf("vec%0d.end_valid", i), 32'(mask_valid), 32'd0);
        end

        // Stall on beat 2 for three cycles
        mask_ready = 1'b0;
        issue(21, 1, 2);
        chk_beat("stall.b1", 32'h0030_0000, 20, 0, 0, 0);
        cyc();
        chk_beat("stall.b1_held", 32'h0030_0000, 20, 0, 0, 0);
        mask_ready = 1'b1;
        cyc();
        chk_beat("stall.b2", 32'h00C0_0000, 22, 0, 0, 0);
        mask_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_beat($sformatf("stall.hold%0d", k), 32'h00C0_0000, 22, 0, 0, 0);
            chk($sformatf("stall.req_ready%0d", k), 32'(req_ready), 32'd0);
        end
        mask_ready = 1'b1;
        cyc();
        chk_beat("stall.b3", 32'h0300_0000, 24, 1, 0, 0);
        cyc();
        chk("stall.end_valid", 32'(mask_valid), 32'd0);

        // Back-to-back: second request accepted in the last-beat handshake cycle
        issue(21, 0, 0);
        chk_beat("b2b.a", 32'h0020_0000, 21, 1, 0, 0);
        req_addr  = 21;
        req_conf  = 1;
        req_len   = 2;
        req_valid = 1'b1;
        #1;
        chk("b2b.req_ready", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        chk_beat("b2b.b1", 32'h0030_0000, 20, 0, 0, 0);
        cyc();
        chk_beat("b2b.b2", 32'h00C0_0000, 22, 0, 0, 0);
        cyc();
        chk_beat("b2b.b3", 32'h0300_0000, 24, 1, 0, 0);
        cyc();
        chk("b2b.end_valid", 32'(mask_valid), 32'd0);

        // Reset mid-burst, then a clean restart
        issue(21, 1, 2);
        chk_beat("mrst.b1", 32'h0030_0000, 20, 0, 0, 0);
        cyc();
        chk_beat("mrst.b2", 32'h00C0_0000, 22, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("mrst.req_ready", 32'(req_ready), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk_idle_outputs("mrst.after");
        chk("mrst.idle_ready", 32'(req_ready), 32'd1);
        issue(29, 3, 2);
        chk_beat("mrst.n1", 32'hFF00_0000, 24, 0, 0, 0);
        cyc();
        chk_beat("mrst.n2", 32'h0000_00FF, 0, 0, 1, 0);
        cyc();
        chk_beat("mrst.n3", 32'h0000_FF00, 8, 1, 0, 0);
        cyc();
        chk("mrst.end_valid", 32'(mask_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
